regfile_sb: RTL and testbench

- Parametrised integer register file for the pipelined core.
- Provides 2 asynchronous read ports, 1 synchronous write port, an optional write-to-read bypass, and a per-register busy scoreboard for RAW hazard detection.
- Sits between decode (read and issue) and writeback (write and clear).
- Register 0 is hardwired to zero.

---
 rtl/regfile_sb.sv | 105 ++++++++++
 tb/tb_regfile_sb.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_sb.sv
// regfile_sb: integer register file with two combinational read ports, one
// synchronous write port, optional write-to-read forwarding and a per-register
// busy scoreboard used by the decode stage for RAW hazard detection.
// Register 0 reads as zero, is never written and is never busy.
module regfile_sb #(
    parameter int WIDTH     = 32,
    parameter int DEPTH     = 32,
    parameter bit BYPASS_EN = 1'b1,
    localparam int AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [AW-1:0]    i_rs1_addr,
    input  logic [AW-1:0]    i_rs2_addr,
    output logic [WIDTH-1:0] o_rs1_data,
    output logic [WIDTH-1:0] o_rs2_data,
    output logic             o_rs1_busy,
    output logic             o_rs2_busy,
    input  logic             i_wr_en,
    input  logic [AW-1:0]    i_wr_addr,
    input  logic [WIDTH-1:0] i_wr_data,
    input  logic             i_iss_en,
    input  logic [AW-1:0]    i_iss_addr,
    input  logic             i_flush,
    output logic [DEPTH-1:0] o_busy_vec
);

    // DEPTH widened by one bit so the range compare also works for
    // power-of-two depths, where every address value is in range.
    localparam logic [AW:0] DEPTH_V = DEPTH[AW:0];

    // Register 0 has no storage; entries 1..DEPTH-1 hold architectural state.
    logic [WIDTH-1:0] mem [1:DEPTH-1];
    logic [DEPTH-1:0] busy;
    logic [DEPTH-1:0] busy_nxt;
    logic             wr_ok;
    logic             iss_ok;

    // An address refers to real storage only if it is nonzero and in range.
    function automatic logic addr_ok(input logic [AW-1:0] a);
        return (a != '0) && ({1'b0, a} < DEPTH_V);
    endfunction

    // Read data: stored value, optionally replaced by a same-cycle write.
    function automatic logic [WIDTH-1:0] rd_data(input logic [AW-1:0] a);
        logic [WIDTH-1:0] d;
        d = '0;
        if (addr_ok(a)) begin
            d = mem[a];
            if (BYPASS_EN && wr_ok && (i_wr_addr == a)) d = i_wr_data;
        end
        return d;
    endfunction

    // Busy view: with forwarding a register being written back is ready now;
    // without it the consumer waits until the data lands in the array.
    function automatic logic rd_busy(input logic [AW-1:0] a);
        logic b;
        logic hit;
        b   = 1'b0;
        hit = 1'b0;
        if (addr_ok(a)) begin
            b   = busy[a];
            hit = wr_ok && (i_wr_addr == a);
        end
        return BYPASS_EN ? (b & ~hit) : (b | hit);
    endfunction

    assign wr_ok  = i_wr_en  && addr_ok(i_wr_addr);
    assign iss_ok = i_iss_en && addr_ok(i_iss_addr);

    // Data array: async clear, then writeback on valid nonzero addresses.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int r = 1; r < DEPTH; r++) mem[r] <= '0;
        end else if (wr_ok) begin
            mem[i_wr_addr] <= i_wr_data;
        end
    end

    // Scoreboard next state: flush clears all, issue wins over writeback clear.
    always_comb begin
        busy_nxt = busy;
        if (i_flush) begin
            busy_nxt = '0;
        end else begin
            if (wr_ok)  busy_nxt[i_wr_addr]  = 1'b0;
            if (iss_ok) busy_nxt[i_iss_addr] = 1'b1;
        end
        busy_nxt[0] = 1'b0;
    end

    // Scoreboard register with async clear.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) busy <= '0;
        else          busy <= busy_nxt;
    end

    assign o_rs1_data = rd_data(i_rs1_addr);
    assign o_rs2_data = rd_data(i_rs2_addr);
    assign o_rs1_busy = rd_busy(i_rs1_addr);
    assign o_rs2_busy = rd_busy(i_rs2_addr);
    assign o_busy_vec = busy;

endmodule

// File: tb/tb_regfile_sb.sv
// tb_regfile_sb: drives one stimulus stream into three register-file variants
// (forwarding 32x32, no forwarding 32x24, forwarding 64x16) and compares every
// output against an array-based reference model each cycle.
module tb_regfile_sb;

    logic        i_clk;
    logic        i_rst_n;
    logic [4:0]  rs1, rs2, wr_addr, iss_addr;
    logic [63:0] wr_data;
    logic        wr_en, iss_en, flush;

    logic [31:0] a_rs1_data, a_rs2_data, b_rs1_data, b_rs2_data;
    logic [63:0] c_rs1_data, c_rs2_data;
    logic        a_rs1_busy, a_rs2_busy, b_rs1_busy, b_rs2_busy, c_rs1_busy, c_rs2_busy;
    logic [31:0] a_busy_vec;
    logic [23:0] b_busy_vec;
    logic [15:0] c_busy_vec;

    int n_checks = 0;
    int n_fail   = 0;

    regfile_sb #(.WIDTH(32), .DEPTH(32), .BYPASS_EN(1'b1)) u_a (
        .i_clk(i_clk), .i_rst_n(i_rst_n),
        .i_rs1_addr(rs1), .i_rs2_addr(rs2),
        .o_rs1_data(a_rs1_data), .o_rs2_data(a_rs2_data),
        .o_rs1_busy(a_rs1_busy), .o_rs2_busy(a_rs2_busy),
        .i_wr_en(wr_en), .i_wr_addr(wr_addr), .i_wr_data(wr_data[31:0]),
        .i_iss_en(iss_en), .i_iss_addr(iss_addr), .i_flush(flush),
        .o_busy_vec(a_busy_vec)
    );

    regfile_sb #(.WIDTH(32), .DEPTH(24), .BYPASS_EN(1'b0)) u_b (
        .i_clk(i_clk), .i_rst_n(i_rst_n),
        .i_rs1_addr(rs1), .i_rs2_addr(rs2),
        .o_rs1_data(b_rs1_data), .o_rs2_data(b_rs2_data),
        .o_rs1_busy(b_rs1_busy), .o_rs2_busy(b_rs2_busy),
        .i_wr_en(wr_en), .i_wr_addr(wr_addr), .i_wr_data(wr_data[31:0]),
        .i_iss_en(iss_en), .i_iss_addr(iss_addr), .i_flush(flush),
        .o_busy_vec(b_busy_vec)
    );

    regfile_sb #(.WIDTH(64), .DEPTH(16), .BYPASS_EN(1'b1)) u_c (
        .i_clk(i_clk), .i_rst_n(i_rst_n),
        .i_rs1_addr(rs1[3:0]), .i_rs2_addr(rs2[3:0]),
        .o_rs1_data(c_rs1_data), .o_rs2_data(c_rs2_data),
        .o_rs1_busy(c_rs1_busy), .o_rs2_busy(c_rs2_busy),
        .i_wr_en(wr_en), .i_wr_addr(wr_addr[3:0]), .i_wr_data(wr_data),
        .i_iss_en(iss_en), .i_iss_addr(iss_addr[3:0]), .i_flush(flush),
        .o_busy_vec(c_busy_vec)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    // Reference model: one data array and busy array per variant.
    logic [63:0] mmem  [3][32];
    bit          mbusy [3][32];
    int          dep   [3] = '{32, 24, 16};
    bit          byp   [3] = '{1'b1, 1'b0, 1'b1};
    logic [63:0] mask  [3] = '{64'h0000_0000_FFFF_FFFF, 64'h0000_0000_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF};

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic int eff(input int k, input int a);
        return (k == 2) ? (a & 15) : a;
    endfunction

    function automatic bit m_ok(input int k, input int a);
        return (a != 0) && (a < dep[k]);
    endfunction

    function automatic bit m_wr_hit(input int k, input int a);
        return wr_en && m_ok(k, a) && (eff(k, int'(wr_addr)) == a);
    endfunction

    function automatic logic [63:0] m_rd(input int k, input int a_in);
        int a = eff(k, a_in);
        if (!m_ok(k, a)) return 64'd0;
        if (byp[k] && m_wr_hit(k, a)) return wr_data & mask[k];
        return mmem[k][a];
    endfunction

    function automatic logic m_busy(input int k, input int a_in);
        int a = eff(k, a_in);
        bit b;
        if (!m_ok(k, a)) return 1'b0;
        b = mbusy[k][a];
        return byp[k] ? (b && !m_wr_hit(k, a)) : (b || m_wr_hit(k, a));
    endfunction

    function automatic logic [63:0] m_vec(input int k);
        logic [63:0] v = '0;
        for (int r = 0; r < dep[k]; r++) v[r] = mbusy[k][r];
        return v;
    endfunction

    task automatic model_clear();
        for (int k = 0; k < 3; k++)
            for (int r = 0; r < 32; r++) begin
                mmem[k][r]  = '0;
                mbusy[k][r] = 1'b0;
            end
    endtask

    // Apply the clock-edge rules to the model using the inputs of this cycle.
    task automatic model_edge();
        for (int k = 0; k < 3; k++) begin
            int wa = eff(k, int'(wr_addr));
            int ia = eff(k, int'(iss_addr));
            for (int r = 1; r < dep[k]; r++) begin
                if (wr_en && wa == r) mmem[k][r] = wr_data & mask[k];
                if (flush)                  mbusy[k][r] = 1'b0;
                else if (iss_en && ia == r) mbusy[k][r] = 1'b1;
                else if (wr_en && wa == r)  mbusy[k][r] = 1'b0;
            end
        end
    endtask

    task automatic check_all();
        for (int k = 0; k < 3; k++) begin
            logic [63:0] g1, g2, gv;
            logic        gb1, gb2;
            case (k)
                0: begin g1 = {32'd0, a_rs1_data}; g2 = {32'd0, a_rs2_data}; gb1 = a_rs1_busy; gb2 = a_rs2_busy; gv = {32'd0, a_busy_vec}; end
                1: begin g1 = {32'd0, b_rs1_data}; g2 = {32'd0, b_rs2_data}; gb1 = b_rs1_busy; gb2 = b_rs2_busy; gv = {40'd0, b_busy_vec}; end
                default: begin g1 = c_rs1_data; g2 = c_rs2_data; gb1 = c_rs1_busy; gb2 = c_rs2_busy; gv = {48'd0, c_busy_vec}; end
            endcase
            check($sformatf("rs1_data[%0d]", k), g1, m_rd(k, int'(rs1)));
            check($sformatf("rs2_data[%0d]", k), g2, m_rd(k, int'(rs2)));
            check($sformatf("rs1_busy[%0d]", k), {63'd0, gb1}, {63'd0, m_busy(k, int'(rs1))});
            check($sformatf("rs2_busy[%0d]", k), {63'd0, gb2}, {63'd0, m_busy(k, int'(rs2))});
            check($sformatf("busy_vec[%0d]", k), gv, m_vec(k));
        end
    endtask

    // Check mid-cycle, then advance the model with the DUT on the edge.
    task automatic step();
        @(negedge i_clk);
        check_all();
        @(posedge i_clk);
        model_edge();
        #1;
    endtask

    task automatic idle();
        wr_en = 1'b0; iss_en = 1'b0; flush = 1'b0;
    endtask

    // Asynchronous reset asserted between edges and released before the next.
    task automatic do_reset();
        idle();
        #2;
        i_rst_n = 1'b0;
        model_clear();
        #1;
        check_all();
        @(negedge i_clk);
        i_rst_n = 1'b1;
        @(posedge i_clk);
        model_edge();
        #1;
    endtask

    initial begin
        i_rst_n = 1'b0;
        rs1 = '0; rs2 = '0; wr_addr = '0; iss_addr = '0; wr_data = '0;
        idle();
        model_clear();
        #3;
        check_all();
        @(negedge i_clk);
        i_rst_n = 1'b1;
        @(posedge i_clk);
        #1;

        // Same-cycle write to x5 seen on both read ports.
        wr_en = 1'b1; wr_addr = 5'd5; wr_data = 64'h0000_0000_DEAD_BEEF; rs1 = 5'd5; rs2 = 5'd5;
        #1;
        check("byp_a_rs1", {32'd0, a_rs1_data}, 64'hDEAD_BEEF);
        check("byp_a_rs2", {32'd0, a_rs2_data}, 64'hDEAD_BEEF);
        check("nobyp_b_rs1_old", {32'd0, b_rs1_data}, 64'd0);
        step();
        idle();
        #1;
        check("nobyp_b_rs1_new", {32'd0, b_rs1_data}, 64'hDEAD_BEEF);

        // Issue x7, then write it back.
        iss_en = 1'b1; iss_addr = 5'd7;
        step();
        idle(); rs1 = 5'd7;
        #1;
        check("iss7_busy", {63'd0, a_rs1_busy}, 64'd1);
        wr_en = 1'b1; wr_addr = 5'd7; wr_data = 64'h12;
        #1;
        check("wb7_ready", {63'd0, a_rs1_busy}, 64'd0);
        check("wb7_data", {32'd0, a_rs1_data}, 64'h12);
        check("wb7_b_stall", {63'd0, b_rs1_busy}, 64'd1);
        step();

        // Issue and older writeback to x9 on the same edge.
        idle(); iss_en = 1'b1; iss_addr = 5'd9; wr_en = 1'b1; wr_addr = 5'd9; wr_data = 64'h55;
        step();
        idle(); rs1 = 5'd9;
        #1;
        check("x9_still_busy", {63'd0, a_busy_vec[9]}, 64'd1);
        check("x9_data", {32'd0, a_rs1_data}, 64'h55);
        wr_en = 1'b1; wr_addr = 5'd9; wr_data = 64'h66;
        step();
        check("x9_cleared", {63'd0, a_busy_vec[9]}, 64'd0);

        // Issue several, then flush together with a new issue.
        idle(); iss_en = 1'b1;
        iss_addr = 5'd3;  step();
        iss_addr = 5'd4;  step();
        iss_addr = 5'd10; step();
        flush = 1'b1; iss_addr = 5'd11; step();
        check("flush_a_vec", {32'd0, a_busy_vec}, 64'd0);
        check("flush_c_vec", {48'd0, c_busy_vec}, 64'd0);

        // Register 0 ignores writes and issues.
        idle(); rs1 = 5'd0; wr_en = 1'b1; wr_addr = 5'd0; wr_data = '1; iss_en = 1'b1; iss_addr = 5'd0;
        #1;
        check("x0_a_data", {32'd0, a_rs1_data}, 64'd0);
        check("x0_c_data", c_rs1_data, 64'd0);
        check("x0_a_busy", {63'd0, a_rs1_busy}, 64'd0);
        step();
        check("x0_a_vec0", {63'd0, a_busy_vec[0]}, 64'd0);
        check("x0_c_vec0", {63'd0, c_busy_vec[0]}, 64'd0);
        check("x0_c_data2", c_rs1_data, 64'd0);

        // Randomized traffic with one mid-run reset.
        for (int i = 0; i < 600; i++) begin
            if (i == 300) do_reset();
            rs1      = 5'($urandom);
            rs2      = ($urandom_range(0, 3) == 0) ? rs1 : 5'($urandom);
            wr_en    = ($urandom_range(0, 1) == 1);
            wr_addr  = ($urandom_range(0, 3) == 0) ? rs1 : 5'($urandom);
            wr_data  = {$urandom, $urandom};
            iss_en   = ($urandom_range(0, 9) < 4);
            iss_addr = ($urandom_range(0, 3) == 0) ? wr_addr : 5'($urandom);
            flush    = ($urandom_range(0, 15) == 0);
            step();
        end

        // Reset with loaded state reads zero immediately.
        idle(); wr_en = 1'b1; wr_addr = 5'd12; wr_data = 64'hABCD; iss_en = 1'b1; iss_addr = 5'd13;
        step();
        rs1 = 5'd12; rs2 = 5'd13;
        do_reset();
        check("rst_a_rs1", {32'd0, a_rs1_data}, 64'd0);
        check("rst_a_vec", {32'd0, a_busy_vec}, 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
